// File: rtl/hb_dec_mac.sv
// Sequencer and multiply-accumulate stage of a 31-tap halfband decimate-by-2 filter.
// Drives the sample RAM ports, then weights, accumulates, rounds and saturates the pair sums it returns.
module hb_dec_mac #(
  parameter logic [143:0]       COEFFS = 144'd0,
  parameter logic signed [17:0] CENTER = 18'sd65536
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        strobe_in,
  input  logic [15:0] data_in,
  output logic        ram_write,
  output logic [4:0]  ram_wr_addr,
  output logic [15:0] ram_wr_data,
  output logic [4:0]  ram_rd_addr1,
  output logic [4:0]  ram_rd_addr2,
  input  logic [15:0] ram_sum,
  output logic        strobe_out,
  output logic [15:0] data_out,
  output logic        overrun
);

  localparam int DATA_W = 16;
  localparam int COEF_W = 18;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = 38;
  localparam int STAGES = 3;
  localparam logic [3:0] LAST_STEP = 4'd8;
  localparam logic signed [ACC_W-1:0] RND_HALF = 38'sd65536;
  localparam logic signed [ACC_W-1:0] SAT_HI   = 38'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_LO   = -38'sd32768;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_q, state_d;

  logic [4:0] wr_ptr_q;
  logic       phase_q;
  logic [4:0] base_q;
  logic [3:0] step_q;
  logic [1:0] drain_q;

  logic       trigger, start, issue, done;
  logic [4:0] base_n, addr1_n, addr2_n, off_n;
  logic [3:0] step_n;

  logic                     vld_p1, vld_p2;
  logic [3:0]               step_p1, step_p2;
  logic signed [DATA_W-1:0] sum_p1;
  logic signed [PROD_W-1:0] prod_p2;
  logic signed [ACC_W-1:0]  prod_ext_p2;
  logic signed [ACC_W-1:0]  acc_p3;

  // Step 8 selects the centre tap; all others index the packed pair coefficients.
  function automatic logic signed [COEF_W-1:0] coef_sel(input logic [3:0] k);
    logic signed [COEF_W-1:0] c;
    if (k >= LAST_STEP) c = CENTER;
    else                c = $signed(COEFFS[int'(k[2:0])*COEF_W +: COEF_W]);
    return c;
  endfunction

  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0]  r;
    logic signed [DATA_W-1:0] y;
    r = (a + RND_HALF) >>> 17;
    if (r > SAT_HI)      y = 16'sh7FFF;
    else if (r < SAT_LO) y = 16'sh8000;
    else                 y = r[DATA_W-1:0];
    return y;
  endfunction

  assign ram_write   = strobe_in;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_wr_data = data_in;

  assign trigger = strobe_in & phase_q;
  assign start   = trigger & (state_q == IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   state_q <= IDLE;
    else if (clear) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (step_q == LAST_STEP) state_d = DRAIN;
      DRAIN:   if (drain_q == 2'(STAGES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Addresses are registered, so compute the ones for the step that runs next cycle.
  always_comb begin
    issue = (state_q == RUN);
    done  = (state_q == DRAIN) && (drain_q == 2'(STAGES - 1));
    if (state_q == IDLE) begin
      base_n = wr_ptr_q;
      step_n = 4'd0;
    end else begin
      base_n = base_q;
      step_n = 4'(step_q + 4'd1);
    end
    off_n = {1'b0, step_n[2:0], 1'b0};
    if (step_n == LAST_STEP) begin
      addr1_n = 5'(base_n + 5'd17);
      addr2_n = 5'(base_n + 5'd17);
    end else begin
      addr1_n = 5'(base_n - off_n);
      addr2_n = 5'(base_n + 5'd2 + off_n);
    end
  end

  // ---- p0: write pointer, read-address issue and tap sequencing ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      phase_q      <= 1'b0;
      overrun      <= 1'b0;
      base_q       <= '0;
      step_q       <= '0;
      drain_q      <= '0;
      ram_rd_addr1 <= '0;
      ram_rd_addr2 <= '0;
    end else if (clear) begin
      wr_ptr_q     <= '0;
      phase_q      <= 1'b0;
      overrun      <= 1'b0;
      base_q       <= '0;
      step_q       <= '0;
      drain_q      <= '0;
      ram_rd_addr1 <= '0;
      ram_rd_addr2 <= '0;
    end else begin
      if (strobe_in) begin
        wr_ptr_q <= 5'(wr_ptr_q + 5'd1);
        phase_q  <= ~phase_q;
      end
      if (trigger && (state_q != IDLE)) overrun <= 1'b1;
      if (state_d == RUN) begin
        base_q       <= base_n;
        step_q       <= step_n;
        ram_rd_addr1 <= addr1_n;
        ram_rd_addr2 <= addr2_n;
      end
      if (state_q == DRAIN) drain_q <= 2'(drain_q + 2'd1);
      else                  drain_q <= '0;
    end
  end

  // ---- p1: RAM returns the halved pair sum; tag it with its step ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      step_p1 <= '0;
      vld_p2  <= 1'b0;
      step_p2 <= '0;
    end else if (clear) begin
      vld_p1  <= 1'b0;
      step_p1 <= '0;
      vld_p2  <= 1'b0;
      step_p2 <= '0;
    end else begin
      vld_p1  <= issue;
      step_p1 <= step_q;
      vld_p2  <= vld_p1;
      step_p2 <= step_p1;
    end
  end

  assign sum_p1 = ram_sum;

  // ---- p2: registered coefficient product ----
  always_ff @(posedge clock) begin
    if (vld_p1) prod_p2 <= PROD_W'(sum_p1) * PROD_W'(coef_sel(step_p1));
  end

  assign prod_ext_p2 = ACC_W'(prod_p2);

  // ---- p3: accumulate (step 0 loads), then round/saturate into the output register ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_p3     <= '0;
      strobe_out <= 1'b0;
      data_out   <= '0;
    end else if (clear) begin
      acc_p3     <= '0;
      strobe_out <= 1'b0;
      data_out   <= '0;
    end else begin
      if (vld_p2) begin
        if (step_p2 == 4'd0) acc_p3 <= prod_ext_p2;
        else                 acc_p3 <= acc_p3 + prod_ext_p2;
      end
      strobe_out <= done;
      if (done) data_out <= round_sat(acc_p3);
    end
  end

endmodule
